// File: rtl/ball_hit_detector.sv
// Pixel mixer with per-frame ball collision accumulation. Contacts are gathered
// during a frame and reported as pulses and a first-hit coordinate after startOfFrame.
module ball_hit_detector #(
    parameter logic [7:0] TRANSPARENT_ENCODING = 8'hFF,
    parameter logic [7:0] BACKGROUND_RGB       = 8'h00
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        ball_dr,
    input  logic [7:0]  ball_rgb,
    input  logic        rope_dr,
    input  logic [7:0]  rope_rgb,
    input  logic        player_dr,
    input  logic [7:0]  player_rgb,
    input  logic        wall_dr,
    input  logic [7:0]  wall_rgb,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic        collision_enable,
    output logic [7:0]  RGBout,
    output logic        hit_rope,
    output logic        hit_wall,
    output logic        hit_player,
    output logic [10:0] hitX,
    output logic [10:0] hitY,
    output logic        hit_valid
);

    logic [7:0]  mix;
    logic        c_rope, c_wall, c_player, c_any;
    logic        acc_rope, acc_wall, acc_player, acc_first;
    logic        prev_player;
    logic [10:0] acc_X, acc_Y;

    // A pixel carrying the transparent code never wins, even with its request set.
    always_comb begin
        mix = BACKGROUND_RGB;
        if (wall_dr   && wall_rgb   != TRANSPARENT_ENCODING) mix = wall_rgb;
        if (ball_dr   && ball_rgb   != TRANSPARENT_ENCODING) mix = ball_rgb;
        if (rope_dr   && rope_rgb   != TRANSPARENT_ENCODING) mix = rope_rgb;
        if (player_dr && player_rgb != TRANSPARENT_ENCODING) mix = player_rgb;
    end

    assign c_rope   = collision_enable & ball_dr & rope_dr;
    assign c_wall   = collision_enable & ball_dr & wall_dr;
    assign c_player = collision_enable & ball_dr & player_dr;
    assign c_any    = c_rope | c_wall | c_player;

    always_ff @(posedge clk) begin
        if (resetN) begin
            RGBout      <= BACKGROUND_RGB;
            hit_rope    <= 1'b0;
            hit_wall    <= 1'b0;
            hit_player  <= 1'b0;
            hit_valid   <= 1'b0;
            hitX        <= '0;
            hitY        <= '0;
            acc_rope    <= 1'b0;
            acc_wall    <= 1'b0;
            acc_player  <= 1'b0;
            acc_first   <= 1'b0;
            acc_X       <= '0;
            acc_Y       <= '0;
            prev_player <= 1'b0;
        end else begin
            RGBout <= mix;
            if (startOfFrame) begin
                hit_rope    <= acc_rope;
                hit_wall    <= acc_wall;
                hit_player  <= acc_player & ~prev_player;
                prev_player <= acc_player;
                hit_valid   <= acc_first;
                hitX        <= acc_first ? acc_X : 11'd0;
                hitY        <= acc_first ? acc_Y : 11'd0;
                // The boundary cycle's own contacts seed the new frame.
                acc_rope    <= c_rope;
                acc_wall    <= c_wall;
                acc_player  <= c_player;
                acc_first   <= c_any;
                acc_X       <= c_any ? pixelX : 11'd0;
                acc_Y       <= c_any ? pixelY : 11'd0;
            end else begin
                hit_rope   <= 1'b0;
                hit_wall   <= 1'b0;
                hit_player <= 1'b0;
                acc_rope   <= acc_rope   | c_rope;
                acc_wall   <= acc_wall   | c_wall;
                acc_player <= acc_player | c_player;
                if (c_any && !acc_first) begin
                    acc_first <= 1'b1;
                    acc_X     <= pixelX;
                    acc_Y     <= pixelY;
                end
            end
        end
    end

endmodule

// File: tb/tb_ball_hit_detector.sv
// Directed vectors for ball_hit_detector; expectations are queued per cycle and
// checked by an independent monitor shortly after each rising edge.
module tb_ball_hit_detector;

    logic        clk = 1'b0;
    logic        resetN;
    logic        ball_dr, rope_dr, player_dr, wall_dr;
    logic [7:0]  ball_rgb, rope_rgb, player_rgb, wall_rgb;
    logic [10:0] pixelX, pixelY;
    logic        startOfFrame, collision_enable;
    logic [7:0]  RGBout;
    logic        hit_rope, hit_wall, hit_player, hit_valid;
    logic [10:0] hitX, hitY;

    ball_hit_detector dut (
        .clk(clk), .resetN(resetN),
        .ball_dr(ball_dr), .ball_rgb(ball_rgb),
        .rope_dr(rope_dr), .rope_rgb(rope_rgb),
        .player_dr(player_dr), .player_rgb(player_rgb),
        .wall_dr(wall_dr), .wall_rgb(wall_rgb),
        .pixelX(pixelX), .pixelY(pixelY),
        .startOfFrame(startOfFrame), .collision_enable(collision_enable),
        .RGBout(RGBout),
        .hit_rope(hit_rope), .hit_wall(hit_wall), .hit_player(hit_player),
        .hitX(hitX), .hitY(hitY), .hit_valid(hit_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        logic [7:0]  rgb;
        logic [2:0]  hit;   // {rope, wall, player}
        logic        v;
        logic [10:0] x;
        logic [10:0] y;
    } exp_t;

    exp_t q[$];
    int   cycle_cnt = 0;
    int   total = 0;
    int   bad = 0;

    // Monitor: one sample per cycle, 1 time unit after the edge.
    always begin
        @(posedge clk);
        cycle_cnt++;
        #1;
        while (q.size() > 0 && q[0].cyc <= cycle_cnt) begin
            exp_t e;
            logic [33:0] act, req;
            e = q.pop_front();
            act = {RGBout, hit_rope, hit_wall, hit_player, hit_valid, hitX, hitY};
            req = {e.rgb, e.hit, e.v, e.x, e.y};
            total++;
            if (e.cyc != cycle_cnt || act !== req) begin
                bad++;
                $display("FAIL %s cyc=%0d/%0d: got rgb=%h hit=%b v=%b x=%0d y=%0d, need rgb=%h hit=%b v=%b x=%0d y=%0d",
                         e.name, cycle_cnt, e.cyc, RGBout, {hit_rope, hit_wall, hit_player},
                         hit_valid, hitX, hitY, e.rgb, e.hit, e.v, e.x, e.y);
            end
        end
    end

    // dr = {ball, rope, player, wall}; expected values describe outputs after this edge.
    task automatic step(input string nm, input logic [3:0] dr, input logic [10:0] x, y,
                        input logic sof, input logic [7:0] ergb, input logic [2:0] ehit,
                        input logic ev, input logic [10:0] ex, ey);
        exp_t e;
        {ball_dr, rope_dr, player_dr, wall_dr} = dr;
        pixelX = x;
        pixelY = y;
        startOfFrame = sof;
        e.cyc = cycle_cnt + 1;
        e.name = nm;
        e.rgb = ergb; e.hit = ehit; e.v = ev; e.x = ex; e.y = ey;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    initial begin
        resetN = 1'b1;
        {ball_dr, rope_dr, player_dr, wall_dr} = 4'b0;
        ball_rgb = 8'h17; rope_rgb = 8'h2A; player_rgb = 8'h1C; wall_rgb = 8'h55;
        pixelX = '0; pixelY = '0;
        startOfFrame = 1'b0;
        collision_enable = 1'b0;
        @(posedge clk);
        #2;

        step("rst0", 4'b0000, 0, 0, 0, 8'h00, 3'b000, 0, 0, 0);
        step("rst1", 4'b1000, 0, 0, 0, 8'h00, 3'b000, 0, 0, 0);
        resetN = 1'b0;

        // Mixer priority, collisions disabled (ball-wall overlap included)
        step("mix_pb",  4'b1010, 1, 1, 0, 8'h1C, 3'b000, 0, 0, 0);
        step("mix_bg",  4'b0000, 1, 1, 0, 8'h00, 3'b000, 0, 0, 0);
        step("mix_b",   4'b1000, 1, 1, 0, 8'h17, 3'b000, 0, 0, 0);
        step("mix_w",   4'b0001, 1, 1, 0, 8'h55, 3'b000, 0, 0, 0);
        step("mix_bw",  4'b1001, 1, 1, 0, 8'h17, 3'b000, 0, 0, 0);
        step("mix_br",  4'b1100, 1, 1, 0, 8'h2A, 3'b000, 0, 0, 0);
        step("mix_rpw", 4'b0111, 1, 1, 0, 8'h1C, 3'b000, 0, 0, 0);
        step("mix_rw",  4'b0101, 1, 1, 0, 8'h2A, 3'b000, 0, 0, 0);
        step("dis_sof", 4'b0000, 0, 0, 1, 8'h00, 3'b000, 0, 0, 0);
        collision_enable = 1'b1;

        // Rope contact, first coordinate kept
        step("rope_a",   4'b1100, 100, 200, 0, 8'h2A, 3'b000, 0, 0, 0);
        step("rope_b",   4'b1100, 110, 205, 0, 8'h2A, 3'b000, 0, 0, 0);
        step("rope_c",   4'b0000, 5, 5, 0, 8'h00, 3'b000, 0, 0, 0);
        step("rope_sof", 4'b0000, 0, 0, 1, 8'h00, 3'b100, 1, 100, 200);
        step("rope_end", 4'b0000, 0, 0, 0, 8'h00, 3'b000, 1, 100, 200);

        // Player rising edge per frame
        step("pl_n",    4'b1010, 300, 40, 0, 8'h1C, 3'b000, 1, 100, 200);
        step("pl_sofn", 4'b0000, 0, 0, 1, 8'h00, 3'b001, 1, 300, 40);
        step("pl_n1",   4'b1010, 301, 41, 0, 8'h1C, 3'b000, 1, 300, 40);
        step("pl_sof1", 4'b0000, 0, 0, 1, 8'h00, 3'b000, 1, 301, 41);
        step("pl_n2",   4'b0000, 0, 0, 0, 8'h00, 3'b000, 1, 301, 41);
        step("pl_sof2", 4'b0000, 0, 0, 1, 8'h00, 3'b000, 0, 0, 0);
        step("pl_n3",   4'b1010, 7, 8, 0, 8'h1C, 3'b000, 0, 0, 0);
        step("pl_sof3", 4'b0000, 0, 0, 1, 8'h00, 3'b001, 1, 7, 8);
        step("pl_sof4", 4'b0000, 0, 0, 1, 8'h00, 3'b000, 0, 0, 0);

        // Contact coincident with startOfFrame belongs to the new frame
        step("bd_sof",  4'b1001, 50, 60, 1, 8'h17, 3'b000, 0, 0, 0);
        step("bd_mid",  4'b0000, 0, 0, 0, 8'h00, 3'b000, 0, 0, 0);
        step("bd_sof2", 4'b0000, 0, 0, 1, 8'h00, 3'b010, 1, 50, 60);
        step("bd_sof3", 4'b0000, 0, 0, 1, 8'h00, 3'b000, 0, 0, 0);
        step("cs_sof1", 4'b1100, 9, 9, 1, 8'h2A, 3'b000, 0, 0, 0);
        step("cs_sof2", 4'b0000, 0, 0, 1, 8'h00, 3'b100, 1, 9, 9);

        // Disable holds already-set bits without adding new ones
        step("en_rope", 4'b1100, 3, 4, 0, 8'h2A, 3'b000, 1, 9, 9);
        collision_enable = 1'b0;
        step("en_wall", 4'b1001, 5, 6, 0, 8'h17, 3'b000, 1, 9, 9);
        collision_enable = 1'b1;
        step("en_sof",  4'b0000, 0, 0, 1, 8'h00, 3'b100, 1, 3, 4);

        // Mid-frame reset discards contacts and the previous-player flag
        step("rs_pl",   4'b1010, 20, 21, 0, 8'h1C, 3'b000, 1, 3, 4);
        step("rs_rope", 4'b1100, 22, 23, 0, 8'h2A, 3'b000, 1, 3, 4);
        resetN = 1'b1;
        step("rs_rst",  4'b0000, 0, 0, 0, 8'h00, 3'b000, 0, 0, 0);
        resetN = 1'b0;
        step("rs_sof",  4'b0000, 0, 0, 1, 8'h00, 3'b000, 0, 0, 0);
        step("rs_pl2",  4'b1010, 1, 2, 0, 8'h1C, 3'b000, 0, 0, 0);
        step("rs_sof2", 4'b0000, 0, 0, 1, 8'h00, 3'b001, 1, 1, 2);
        step("rs_end",  4'b0000, 0, 0, 0, 8'h00, 3'b000, 1, 1, 2);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, need 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ball_hit_detector.md
BALL_HIT_DETECTOR -- requirements
Module: ball_hit_detector

Interface
REQ-001 The block SHALL have parameter TRANSPARENT_ENCODING, default 8'hFF, the pixel value meaning "not drawn".
REQ-002 The block SHALL have parameter BACKGROUND_RGB, default 8'h00, the colour output when no object draws.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port resetN, input, 1, a reset that is synchronous and active-high; the name follows the codebase port convention.
REQ-005 The block SHALL have ports ball_dr/ball_rgb, input, 1/8, the ball bitmap drawing request and pixel colour.
REQ-006 The block SHALL have ports rope_dr/rope_rgb, input, 1/8, the rope drawing request and pixel colour.
REQ-007 The block SHALL have ports player_dr/player_rgb, input, 1/8, the player drawing request and pixel colour.
REQ-008 The block SHALL have ports wall_dr/wall_rgb, input, 1/8, the border and floor drawing request and pixel colour.
REQ-009 The block SHALL have ports pixelX/pixelY, input, 11/11, the current scan coordinate, aligned with the *_dr inputs.
REQ-010 The block SHALL have port startOfFrame, input, 1, a one-cycle pulse on the first pixel of each frame.
REQ-011 The block SHALL have port collision_enable, input, 1; when low, no collision is accumulated.
REQ-012 The block SHALL have port RGBout, output, 8, the registered mixed pixel colour.
REQ-013 The block SHALL have ports hit_rope/hit_wall/hit_player, output, 1 each, single-cycle collision report pulses.
REQ-014 The block SHALL have ports hitX/hitY/hit_valid, output, 11/11/1, the first ball-collision coordinate of the previous frame.

Function
REQ-015 Mixer priority SHALL be player > rope > ball > wall > BACKGROUND_RGB; a source is eligible only when its *_dr input is 1.
REQ-016 RGBout SHALL be registered, with exactly 1 clk of latency from the *_dr/*_rgb inputs.
REQ-017 A contact event SHALL be ball_dr=1 together with rope_dr, wall_dr or player_dr =1 in the same cycle, while collision_enable=1.
REQ-018 Each contact type SHALL set its own sticky frame accumulator (acc_rope, acc_wall, acc_player), which stays set until the frame boundary.
REQ-019 The first contact of any type in a frame SHALL capture pixelX/pixelY into acc_X/acc_Y; later contacts in the same frame SHALL NOT overwrite them.
REQ-020 On a startOfFrame cycle, the accumulators SHALL transfer to the report stage and then clear.
REQ-021 Contacts in the startOfFrame cycle itself SHALL count toward the new frame, never the one being reported.
REQ-022 hit_rope and hit_wall SHALL pulse high for exactly 1 cycle, one cycle after startOfFrame, if the corresponding accumulator was set.
REQ-023 hit_player SHALL pulse only when acc_player was set for the ending frame and clear for the frame before it (rising-edge per frame).
REQ-024 hitX/hitY/hit_valid SHALL update one cycle after startOfFrame and hold until the next update.
REQ-025 hit_valid SHALL be 1 iff any contact occurred in the reported frame; when hit_valid=0, hitX and hitY SHALL be 0.
REQ-026 When collision_enable is low, accumulators SHALL hold their value without setting further bits, and the frame transfer SHALL still occur.
REQ-027 If startOfFrame pulses on consecutive cycles, each pulse SHALL perform a transfer, with the second reporting an empty frame unless contacts occurred between them.

Reset
REQ-028 While resetN=1 at a clk edge, the block SHALL set RGBout=BACKGROUND_RGB, all hit_* =0, hit_valid=0 and hitX=hitY=0.
REQ-029 While resetN=1 at a clk edge, the block SHALL clear all accumulators, the captured first-hit flag and the previous-frame player flag.
REQ-030 Reset asserted mid-frame SHALL discard all accumulated contacts, and no pulse SHALL follow the next startOfFrame.

Verification
REQ-031 Mixer test: player_dr=1/rgb=8'h1C with ball_dr=1/rgb=8'h17 -> RGBout=8'h1C next cycle; with all *_dr=0 -> RGBout=8'h00.
REQ-032 Rope contact test: ball_dr & rope_dr at (100,200), then at (110,205), then startOfFrame -> hit_rope=1 for 1 cycle, hitX=100, hitY=200, hit_valid=1.
REQ-033 Player edge test: ball-player contact in frames N and N+1 -> hit_player pulses after frame N only; no contact in N+2, contact in N+3 -> pulses again.
REQ-034 Boundary test: contact coincident with startOfFrame -> no pulse at this boundary; pulse at the following boundary.
REQ-035 Disable test: collision_enable=0 during ball-wall overlap -> hit_wall stays 0 and hit_valid=0 after startOfFrame.
REQ-036 Reset test: contact, then resetN=1 for 1 cycle, then startOfFrame -> no hit_* pulse and hit_valid=0.
